// File: rtl/lcd_nibble_writer.sv
// Sends one byte to the Spartan-3E character LCD as two 4-bit nibbles.
// The upper nibble goes first, with setup, LCD_E high and hold timing.
module lcd_nibble_writer #(
  parameter int SETUP_CYCLES      = 2,
  parameter int EN_HIGH_CYCLES    = 12,
  parameter int HOLD_CYCLES       = 1,
  parameter int NIBBLE_GAP_CYCLES = 50,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CNT_W             = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWriteBegin,
  input  logic [7:0] iData,
  output logic       oWriteDone,
  output logic [3:0] oSender,
  output logic       oLCD_EN
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HI_SETUP,
    S_HI_EN,
    S_HI_HOLD,
    S_GAP,
    S_LO_SETUP,
    S_LO_EN,
    S_LO_HOLD,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_EN    = CNT_W'(EN_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_WAIT  = CNT_W'(CMD_WAIT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_byte;

  state_t           w_nxt;
  logic [CNT_W-1:0] w_lim;
  logic             w_timed;
  logic             w_last;
  logic [7:0]       w_byte_nxt;

  always_comb begin
    w_lim   = '0;
    w_timed = 1'b1;
    unique case (r_state)
      S_HI_SETUP, S_LO_SETUP: w_lim = L_SETUP;
      S_HI_EN, S_LO_EN:       w_lim = L_EN;
      S_HI_HOLD, S_LO_HOLD:   w_lim = L_HOLD;
      S_GAP:                  w_lim = L_GAP;
      S_WAIT:                 w_lim = L_WAIT;
      default:                w_timed = 1'b0;
    endcase
  end

  assign w_last = (r_cnt == w_lim);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (iWriteBegin) w_nxt = S_HI_SETUP;
      S_HI_SETUP: if (w_last) w_nxt = S_HI_EN;
      S_HI_EN:    if (w_last) w_nxt = S_HI_HOLD;
      S_HI_HOLD:  if (w_last) w_nxt = S_GAP;
      S_GAP:      if (w_last) w_nxt = S_LO_SETUP;
      S_LO_SETUP: if (w_last) w_nxt = S_LO_EN;
      S_LO_EN:    if (w_last) w_nxt = S_LO_HOLD;
      S_LO_HOLD:  if (w_last) w_nxt = S_WAIT;
      S_WAIT:     if (w_last) w_nxt = S_DONE;
      S_DONE:     w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  // The byte is only ever loaded on the IDLE edge that accepts a request.
  assign w_byte_nxt = (r_state == S_IDLE && iWriteBegin) ? iData : r_byte;

  // Outputs are registered from the next state so pins change cleanly on the edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_byte     <= 8'h00;
      oWriteDone <= 1'b0;
      oSender    <= 4'h0;
      oLCD_EN    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_byte  <= w_byte_nxt;
      if (w_nxt != r_state || !w_timed)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      oWriteDone <= 1'b0;
      oSender    <= 4'h0;
      oLCD_EN    <= 1'b0;
      unique case (w_nxt)
        S_HI_SETUP, S_HI_HOLD: oSender <= w_byte_nxt[7:4];
        S_LO_SETUP, S_LO_HOLD: oSender <= w_byte_nxt[3:0];
        S_HI_EN: begin
          oSender <= w_byte_nxt[7:4];
          oLCD_EN <= 1'b1;
        end
        S_LO_EN: begin
          oSender <= w_byte_nxt[3:0];
          oLCD_EN <= 1'b1;
        end
        S_DONE:  oWriteDone <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed testbench for lcd_nibble_writer.
// Covers default timing, back-to-back bytes, reset and minimum parameters.
module tb_lcd_nibble_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wbeg = 1'b0;
  logic [7:0] wdat = 8'h00;
  logic       done;
  logic [3:0] snd;
  logic       en;

  logic       rst2 = 1'b1;
  logic       wbeg2 = 1'b0;
  logic [7:0] wdat2 = 8'h00;
  logic       done2;
  logic [3:0] snd2;
  logic       en2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lcd_nibble_writer dut (
    .Clock(clk), .Reset(rst), .iWriteBegin(wbeg), .iData(wdat),
    .oWriteDone(done), .oSender(snd), .oLCD_EN(en)
  );

  lcd_nibble_writer #(
    .SETUP_CYCLES(1), .EN_HIGH_CYCLES(1), .HOLD_CYCLES(1),
    .NIBBLE_GAP_CYCLES(1), .CMD_WAIT_CYCLES(1), .CNT_W(16)
  ) dut2 (
    .Clock(clk), .Reset(rst2), .iWriteBegin(wbeg2), .iData(wdat2),
    .oWriteDone(done2), .oSender(snd2), .oLCD_EN(en2)
  );

  // Expected {done, en, sender} for cycle c of a default-timing transfer.
  function automatic logic [5:0] exp_def(input int c, input logic [7:0] b);
    logic [5:0] v;
    v = 6'h00;
    if (c >= 1 && c <= 15) v[3:0] = b[7:4];
    if (c >= 3 && c <= 14) v[4] = 1'b1;
    if (c >= 66 && c <= 80) v[3:0] = b[3:0];
    if (c >= 68 && c <= 79) v[4] = 1'b1;
    if (c == 2081) v[5] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    wbeg = 1'b1;
    wdat = 8'h28;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({done, en, snd} !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_hold got=%h want=00", {done, en, snd});
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({done, en, snd} !== 6'h02) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=02", {done, en, snd});
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({done, en, snd} !== 6'h12) begin
      n_fail++;
      $display("FAIL pre_reset_en got=%h want=12", {done, en, snd});
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({done, en, snd} !== 6'h00) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=00", {done, en, snd});
    end
    wbeg = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({done, en, snd} !== 6'h00) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%h want=00", {done, en, snd});
    end
  endtask

  task automatic test_single();
    wbeg = 1'b1;
    wdat = 8'h28;
    for (int c = 1; c <= 2083; c++) begin
      @(negedge clk);
      if (c == 2081) wbeg = 1'b0;
      n_chk++;
      if ({done, en, snd} !== exp_def(c, 8'h28)) begin
        n_fail++;
        $display("FAIL single c=%0d got=%h want=%h",
                 c, {done, en, snd}, exp_def(c, 8'h28));
      end
    end
  endtask

  task automatic test_ignore_change();
    wbeg = 1'b1;
    wdat = 8'h5A;
    for (int c = 1; c <= 2083; c++) begin
      @(negedge clk);
      if (c == 5) begin
        wbeg = 1'b0;
        wdat = 8'hFF;
      end
      n_chk++;
      if ({done, en, snd} !== exp_def(c, 8'h5A)) begin
        n_fail++;
        $display("FAIL ignore c=%0d got=%h want=%h",
                 c, {done, en, snd}, exp_def(c, 8'h5A));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    logic [3:0] want [8];
    logic [3:0] got [$];
    int dcyc [$];
    int idx;
    logic pen;
    bytes = '{8'h28, 8'h06, 8'h0C, 8'h01};
    want  = '{4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    idx = 0;
    pen = 1'b0;
    wbeg = 1'b1;
    wdat = bytes[0];
    for (int c = 1; c <= 4 * 2082 + 20; c++) begin
      @(negedge clk);
      if (en && !pen) got.push_back(snd);
      pen = en;
      if (done) begin
        dcyc.push_back(c);
        idx++;
        if (idx < 4) wdat = bytes[idx];
        else wbeg = 1'b0;
      end
    end
    n_chk++;
    if (dcyc.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_done_count got=%0d want=4", dcyc.size());
    end
    n_chk++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_nibble_count got=%0d want=8", got.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        n_chk++;
        if (got[i] !== want[i]) begin
          n_fail++;
          $display("FAIL b2b_nibble%0d got=%h want=%h", i, got[i], want[i]);
        end
      end
    end
    for (int i = 0; i < dcyc.size(); i++) begin
      n_chk++;
      if (dcyc[i] != 2081 + i * 2082) begin
        n_fail++;
        $display("FAIL b2b_done%0d got=%0d want=%0d",
                 i, dcyc[i], 2081 + i * 2082);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    wbeg = 1'b1;
    wdat = 8'h5A;
    for (int c = 1; c <= 70; c++) @(negedge clk);
    n_chk++;
    if ({done, en, snd} !== 6'h1A) begin
      n_fail++;
      $display("FAIL mid_lo_en got=%h want=1a", {done, en, snd});
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({done, en, snd} !== 6'h00) begin
      n_fail++;
      $display("FAIL mid_reset got=%h want=00", {done, en, snd});
    end
    wbeg = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 2100; c++) begin
      @(negedge clk);
      if (done || en || snd != 4'h0) ndone++;
    end
    n_chk++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL mid_quiet active_cycles=%0d want=0", ndone);
    end
    wbeg = 1'b1;
    wdat = 8'h5A;
    for (int c = 1; c <= 2083; c++) begin
      @(negedge clk);
      if (c == 2081) wbeg = 1'b0;
      n_chk++;
      if ({done, en, snd} !== exp_def(c, 8'h5A)) begin
        n_fail++;
        $display("FAIL after_reset c=%0d got=%h want=%h",
                 c, {done, en, snd}, exp_def(c, 8'h5A));
      end
    end
  endtask

  task automatic test_min_params();
    logic [5:0] tbl [10];
    tbl = '{6'h0A, 6'h1A, 6'h0A, 6'h00, 6'h05,
            6'h15, 6'h05, 6'h00, 6'h20, 6'h00};
    @(negedge clk);
    n_chk++;
    if ({done2, en2, snd2} !== 6'h00) begin
      n_fail++;
      $display("FAIL min_reset got=%h want=00", {done2, en2, snd2});
    end
    rst2 = 1'b0;
    wbeg2 = 1'b1;
    wdat2 = 8'hA5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 9) wbeg2 = 1'b0;
      n_chk++;
      if ({done2, en2, snd2} !== tbl[c-1]) begin
        n_fail++;
        $display("FAIL min c=%0d got=%h want=%h",
                 c, {done2, en2, snd2}, tbl[c-1]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_ignore_change();
    test_back_to_back();
    test_reset_mid();
    test_min_params();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
